// File: rtl/ex_stage_muldiv.sv
// Execute stage of an in-order RISC-V style pipeline: operand forwarding, single-cycle ALU,
// and an iterative shift-add multiplier that stalls upstream while it runs.
module ex_stage_muldiv #(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic            flush_in,
  output logic            stall_out,
  input  logic [XLEN-1:0] reg_a_in,
  input  logic [XLEN-1:0] reg_b_in,
  input  logic [XLEN-1:0] immediate_in,
  input  logic [4:0]      ctrl_in,
  input  logic            aluSrc_in,
  input  logic [1:0]      aluOp_in,
  input  logic [6:0]      funct7_in,
  input  logic [2:0]      funct3_in,
  input  logic [RW-1:0]   reg_rs1_in,
  input  logic [RW-1:0]   reg_rs2_in,
  input  logic [RW-1:0]   reg_rd_in,
  input  logic [RW-1:0]   ex_mem_reg_rd,
  input  logic            ex_mem_reg_write,
  input  logic [XLEN-1:0] alu_ex_mem,
  input  logic [RW-1:0]   mem_wb_reg_rd,
  input  logic            mem_wb_reg_write,
  input  logic [XLEN-1:0] alu_data_mem_wb,
  output logic            valid_out,
  output logic [4:0]      ctrl_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] mux2_result_out,
  output logic [RW-1:0]   reg_rd_out,
  output logic            flag_beq_out
);

  localparam int            SW         = $clog2(XLEN);
  localparam logic [SW-1:0] COUNT_INIT = SW'(XLEN - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   count_q, count_d;

  logic [XLEN-1:0] op_a, op_b_fwd, op_b;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] alu_res;
  logic            beq_flag;
  logic            is_mul;

  logic            accept_mul, finish_mul, load_alu;

  logic [XLEN-1:0] mcand_q, mplier_q, acc_q, acc_next;
  logic [4:0]      mul_ctrl_q;
  logic [RW-1:0]   mul_rd_q;
  logic [XLEN-1:0] mul_store_q;

  // EX/MEM is the younger producer, so it is tested first and wins a double match.
  always_comb begin
    if (ex_mem_reg_write && (ex_mem_reg_rd != '0) && (ex_mem_reg_rd == reg_rs1_in))
      op_a = alu_ex_mem;
    else if (mem_wb_reg_write && (mem_wb_reg_rd != '0) && (mem_wb_reg_rd == reg_rs1_in))
      op_a = alu_data_mem_wb;
    else
      op_a = reg_a_in;

    if (ex_mem_reg_write && (ex_mem_reg_rd != '0) && (ex_mem_reg_rd == reg_rs2_in))
      op_b_fwd = alu_ex_mem;
    else if (mem_wb_reg_write && (mem_wb_reg_rd != '0) && (mem_wb_reg_rd == reg_rs2_in))
      op_b_fwd = alu_data_mem_wb;
    else
      op_b_fwd = reg_b_in;
  end

  assign op_b  = aluSrc_in ? immediate_in : op_b_fwd;
  assign shamt = op_b[SW-1:0];

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    alu_res  = '0;
    beq_flag = 1'b0;
    is_mul   = 1'b0;
    case (aluOp_in)
      2'b00: alu_res = op_a + op_b;
      2'b01: begin
        alu_res  = op_a - op_b;
        beq_flag = (op_a == op_b);
      end
      2'b11: alu_res = op_b;
      default: begin
        case (funct3_in)
          3'b000: begin
            if ((funct7_in == 7'b0000001) && !aluSrc_in) is_mul = 1'b1;
            else if (funct7_in[5] && !aluSrc_in)         alu_res = op_a - op_b;
            else                                         alu_res = op_a + op_b;
          end
          3'b111: alu_res = op_a & op_b;
          3'b110: alu_res = op_a | op_b;
          3'b100: alu_res = op_a ^ op_b;
          3'b001: alu_res = op_a << shamt;
          3'b101: alu_res = funct7_in[5] ? XLEN'($signed(op_a) >>> shamt) : (op_a >> shamt);
          3'b010: alu_res = XLEN'($signed(op_a) < $signed(op_b));
          default: alu_res = '0;
        endcase
      end
    endcase
  end

  // Stall drops in the final BUSY cycle so upstream retires the held MUL on the completing edge.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    stall_out  = 1'b0;
    accept_mul = 1'b0;
    finish_mul = 1'b0;
    load_alu   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in && is_mul) begin
          stall_out  = 1'b1;
          accept_mul = 1'b1;
          state_d    = BUSY;
          count_d    = COUNT_INIT;
        end else if (valid_in) begin
          load_alu = 1'b1;
        end
      end
      BUSY: begin
        stall_out = (count_q != '0);
        if (count_q == '0) begin
          finish_mul = 1'b1;
          state_d    = IDLE;
        end else begin
          count_d = count_q - SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_in) begin
      state_d    = IDLE;
      count_d    = '0;
      stall_out  = 1'b0;
      accept_mul = 1'b0;
      finish_mul = 1'b0;
      load_alu   = 1'b0;
    end
    if (!rst_n) stall_out = 1'b0;
  end

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      mul_ctrl_q  <= '0;
      mul_rd_q    <= '0;
      mul_store_q <= '0;
    end else if (accept_mul) begin
      mcand_q     <= op_a;
      mplier_q    <= op_b_fwd;
      acc_q       <= '0;
      mul_ctrl_q  <= ctrl_in;
      mul_rd_q    <= reg_rd_in;
      mul_store_q <= op_b_fwd;
    end else if (state_q == BUSY) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  // Bubbles only clear valid/ctrl; the data fields keep their old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out       <= 1'b0;
      ctrl_out        <= '0;
      alu_result_out  <= '0;
      mux2_result_out <= '0;
      reg_rd_out      <= '0;
      flag_beq_out    <= 1'b0;
    end else if (load_alu) begin
      valid_out       <= 1'b1;
      ctrl_out        <= ctrl_in;
      alu_result_out  <= alu_res;
      mux2_result_out <= op_b_fwd;
      reg_rd_out      <= reg_rd_in;
      flag_beq_out    <= beq_flag;
    end else if (finish_mul) begin
      valid_out       <= 1'b1;
      ctrl_out        <= mul_ctrl_q;
      alu_result_out  <= acc_next;
      mux2_result_out <= mul_store_q;
      reg_rd_out      <= mul_rd_q;
      flag_beq_out    <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      ctrl_out  <= '0;
    end
  end

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Scoreboard bench for ex_stage_muldiv: stimulus pushes expected results computed from a
// plain-arithmetic reference model; a negedge monitor pops and compares on valid_out.
module tb_ex_stage_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, flush_in, stall_out;
  logic [31:0] reg_a_in, reg_b_in, immediate_in;
  logic [4:0]  ctrl_in;
  logic        aluSrc_in;
  logic [1:0]  aluOp_in;
  logic [6:0]  funct7_in;
  logic [2:0]  funct3_in;
  logic [4:0]  reg_rs1_in, reg_rs2_in, reg_rd_in;
  logic [4:0]  ex_mem_reg_rd, mem_wb_reg_rd;
  logic        ex_mem_reg_write, mem_wb_reg_write;
  logic [31:0] alu_ex_mem, alu_data_mem_wb;
  logic        valid_out;
  logic [4:0]  ctrl_out;
  logic [31:0] alu_result_out, mux2_result_out;
  logic [4:0]  reg_rd_out;
  logic        flag_beq_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        src;
    logic [31:0] a, b, imm;
    logic [4:0]  rs1, rs2, rd, ctrl;
    logic [4:0]  exrd;
    logic        exw;
    logic [31:0] exd;
    logic [4:0]  wbrd;
    logic        wbw;
    logic [31:0] wbd;
  } instr_t;

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [31:0] result;
    logic [31:0] mux2;
    logic [4:0]  rd;
    logic        flag;
  } exp_t;

  exp_t sb[$];

  ex_stage_muldiv #(.XLEN(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .flush_in(flush_in), .stall_out(stall_out),
    .reg_a_in(reg_a_in), .reg_b_in(reg_b_in), .immediate_in(immediate_in), .ctrl_in(ctrl_in),
    .aluSrc_in(aluSrc_in), .aluOp_in(aluOp_in), .funct7_in(funct7_in), .funct3_in(funct3_in),
    .reg_rs1_in(reg_rs1_in), .reg_rs2_in(reg_rs2_in), .reg_rd_in(reg_rd_in),
    .ex_mem_reg_rd(ex_mem_reg_rd), .ex_mem_reg_write(ex_mem_reg_write), .alu_ex_mem(alu_ex_mem),
    .mem_wb_reg_rd(mem_wb_reg_rd), .mem_wb_reg_write(mem_wb_reg_write),
    .alu_data_mem_wb(alu_data_mem_wb), .valid_out(valid_out), .ctrl_out(ctrl_out),
    .alu_result_out(alu_result_out), .mux2_result_out(mux2_result_out),
    .reg_rd_out(reg_rd_out), .flag_beq_out(flag_beq_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: forwarding priority and ALU semantics in plain arithmetic.
  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf, input instr_t i);
    if (i.exw && i.exrd != 0 && i.exrd == rs) return i.exd;
    if (i.wbw && i.wbrd != 0 && i.wbrd == rs) return i.wbd;
    return rf;
  endfunction

  function automatic bit ref_is_mul(input instr_t i);
    return i.op == 2'b10 && i.f3 == 3'b000 && i.f7 == 7'b0000001 && !i.src;
  endfunction

  function automatic logic [31:0] ref_alu(input instr_t i, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    case (i.op)
      2'b00: return a + b;
      2'b01: return a - b;
      2'b11: return b;
      default: case (i.f3)
        3'b000: begin
          if (ref_is_mul(i)) begin
            prod = 64'(a) * 64'(b);
            return prod[31:0];
          end
          if (i.f7[5] && !i.src) return a - b;
          return a + b;
        end
        3'b111: return a & b;
        3'b110: return a | b;
        3'b100: return a ^ b;
        3'b001: return a << b[4:0];
        3'b101: return i.f7[5] ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
        3'b010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: return 32'd0;
      endcase
    endcase
  endfunction

  function automatic instr_t mk(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a, input logic [31:0] b);
    instr_t i;
    i = '0;
    i.op = op; i.f3 = f3; i.f7 = f7; i.a = a; i.b = b;
    i.rs1 = 5'd11; i.rs2 = 5'd12; i.rd = 5'd7; i.ctrl = 5'b01000;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    aluOp_in = i.op; funct3_in = i.f3; funct7_in = i.f7; aluSrc_in = i.src;
    reg_a_in = i.a; reg_b_in = i.b; immediate_in = i.imm;
    reg_rs1_in = i.rs1; reg_rs2_in = i.rs2; reg_rd_in = i.rd; ctrl_in = i.ctrl;
    ex_mem_reg_rd = i.exrd; ex_mem_reg_write = i.exw; alu_ex_mem = i.exd;
    mem_wb_reg_rd = i.wbrd; mem_wb_reg_write = i.wbw; alu_data_mem_wb = i.wbd;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the instruction's result edge.
  task automatic issue(input instr_t i);
    exp_t e;
    logic [31:0] a, bm, b;
    int n;
    drive(i);
    valid_in = 1'b1;
    a  = fwd(i.rs1, i.a, i);
    bm = fwd(i.rs2, i.b, i);
    b  = i.src ? i.imm : bm;
    e.ctrl = i.ctrl; e.result = ref_alu(i, a, b); e.mux2 = bm; e.rd = i.rd;
    e.flag = (i.op == 2'b01) && (a == b);
    #1;
    sb.push_back(e);
    if (!ref_is_mul(i)) begin
      check("stall_low_alu", 64'(stall_out), 64'd0);
      @(posedge clk); #1;
    end else begin
      n = 0;
      while (stall_out === 1'b1 && n < 100) begin
        n++;
        @(posedge clk); #1;
      end
      check("mul_stall_cycles", 64'(n), 64'd32);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int cycles);
    valid_in = 1'b0;
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid_out", 64'(valid_out), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 64'(alu_result_out), 64'(e.result));
        check("ctrl",   64'(ctrl_out),       64'(e.ctrl));
        check("mux2",   64'(mux2_result_out), 64'(e.mux2));
        check("rd",     64'(reg_rd_out),     64'(e.rd));
        check("flag",   64'(flag_beq_out),   64'(e.flag));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},  64'(valid_out),       64'd0);
    check({tag, "_ctrl"},   64'(ctrl_out),        64'd0);
    check({tag, "_result"}, 64'(alu_result_out),  64'd0);
    check({tag, "_mux2"},   64'(mux2_result_out), 64'd0);
    check({tag, "_rd"},     64'(reg_rd_out),      64'd0);
    check({tag, "_flag"},   64'(flag_beq_out),    64'd0);
    check({tag, "_stall"},  64'(stall_out),       64'd0);
  endtask

  initial begin
    instr_t i;
    logic [2:0] f3_tab [7];
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};

    rst_n = 1'b0; valid_in = 1'b0; flush_in = 1'b0;
    drive('0);
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // ADD 5+3
    issue(mk(2'b10, 3'b000, 7'b0000000, 32'd5, 32'd3));
    check("add_literal", 64'(alu_result_out), 64'd8);
    // SUB 5-3
    issue(mk(2'b10, 3'b000, 7'b0100000, 32'd5, 32'd3));
    check("sub_literal", 64'(alu_result_out), 64'd2);
    // OR
    issue(mk(2'b10, 3'b110, 7'b0000000, 32'h81000081, 32'h00818100));
    check("or_literal", 64'(alu_result_out), 64'h81818181);
    // Branch compare, equal operands
    issue(mk(2'b01, 3'b000, 7'b0000000, 32'h10000005, 32'h10000005));
    check("beq_literal", 64'(flag_beq_out), 64'd1);
    idle(1);

    // Forwarding: rs1 from EX/MEM, rs2 from MEM/WB
    i = mk(2'b00, 3'b000, 7'b0, 32'd100, 32'd200);
    i.rs1 = 5'd1; i.rs2 = 5'd2;
    i.exw = 1'b1; i.exrd = 5'd1; i.exd = 32'd9;
    i.wbw = 1'b1; i.wbrd = 5'd2; i.wbd = 32'd1;
    issue(i);
    check("fwd_both_literal", 64'(alu_result_out), 64'hA);
    // Both stages target rs1: EX/MEM wins
    i.wbrd = 5'd1; i.wbd = 32'd50;
    issue(i);
    check("fwd_priority_literal", 64'(alu_result_out), 64'd209);
    // x0 is never forwarded
    i.rs1 = 5'd0; i.rs2 = 5'd0; i.exrd = 5'd0; i.wbrd = 5'd0;
    issue(i);
    check("fwd_x0_literal", 64'(alu_result_out), 64'd300);
    idle(1);

    // MUL 7*6 and 0xFFFFFFFF*2
    issue(mk(2'b10, 3'b000, 7'b0000001, 32'd7, 32'd6));
    check("mul_literal", 64'(alu_result_out), 64'h2A);
    idle(1);
    issue(mk(2'b10, 3'b000, 7'b0000001, 32'hFFFFFFFF, 32'd2));
    check("mul_wrap_literal", 64'(alu_result_out), 64'hFFFFFFFE);
    idle(1);

    // Flush at BUSY cycle 10: no result, next ADD completes in one cycle
    drive(mk(2'b10, 3'b000, 7'b0000001, 32'd123, 32'd456));
    valid_in = 1'b1;
    #1;
    check("mul_accept_stall", 64'(stall_out), 64'd1);
    repeat (10) begin @(posedge clk); #1; end
    flush_in = 1'b1;
    #1;
    check("flush_stall_low", 64'(stall_out), 64'd0);
    @(posedge clk); #1;
    flush_in = 1'b0;
    check("flush_valid_low", 64'(valid_out), 64'd0);
    issue(mk(2'b00, 3'b000, 7'b0, 32'd20, 32'd22));
    check("post_flush_add", 64'(alu_result_out), 64'd42);
    idle(40);

    // Reset in the middle of a MUL
    drive(mk(2'b10, 3'b000, 7'b0000001, 32'd9, 32'd9));
    valid_in = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_all_zero("midmul_reset");
    valid_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(40);

    // Randomized mix with forwarding hazards on a small register range
    for (int k = 0; k < 80; k++) begin
      i = '0;
      i.op   = 2'($urandom_range(0, 3));
      i.f3   = f3_tab[$urandom_range(0, 6)];
      case ($urandom_range(0, 2))
        0: i.f7 = 7'b0000000;
        1: i.f7 = 7'b0100000;
        default: i.f7 = 7'b0000001;
      endcase
      i.src  = 1'($urandom_range(0, 1));
      i.a    = $urandom; i.b = $urandom; i.imm = $urandom;
      i.rs1  = 5'($urandom_range(0, 3)); i.rs2 = 5'($urandom_range(0, 3));
      i.rd   = 5'($urandom); i.ctrl = 5'($urandom);
      i.exrd = 5'($urandom_range(0, 3)); i.exw = 1'($urandom_range(0, 1)); i.exd = $urandom;
      i.wbrd = 5'($urandom_range(0, 3)); i.wbw = 1'($urandom_range(0, 1)); i.wbd = $urandom;
      if ($urandom_range(0, 6) == 0) begin
        i.op = 2'b10; i.f3 = 3'b000; i.f7 = 7'b0000001; i.src = 1'b0;
      end
      issue(i);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(5);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage_muldiv.md
EX_STAGE_MULDIV -- requirements
Module: ex_stage_muldiv

Interface
REQ-001 XLEN, default 32, operand/result width (>=8, even).
REQ-002 RW, default 5, register-address width.
REQ-003 clock  input  1  sole clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-low.
REQ-005 valid_in  input  1  instruction present in ID/EX.
REQ-006 flush_in  input  1  synchronous squash of the EX instruction and the EX/MEM register load.
REQ-007 stall_out  output  1  upstream SHALL hold all inputs while high.
REQ-008 reg_a_in, reg_b_in  input  XLEN each  register operands.
REQ-009 immediate_in  input  XLEN  sign-extended immediate.
REQ-010 ctrl_in  input  5  {mem_to_reg, reg_write, mem_read, mem_write, beq_instruction}.
REQ-011 aluSrc_in  input  1  1 = immediate as operand B.
REQ-012 aluOp_in  input  2  operation class.
REQ-013 funct7_in  input  7  funct7 field.
REQ-014 funct3_in  input  3  funct3 field.
REQ-015 reg_rs1_in, reg_rs2_in, reg_rd_in  input  RW each  source/destination addresses.
REQ-016 ex_mem_reg_rd, ex_mem_reg_write, alu_ex_mem  input  RW/1/XLEN  EX/MEM forwarding source.
REQ-017 mem_wb_reg_rd, mem_wb_reg_write, alu_data_mem_wb  input  RW/1/XLEN  MEM/WB forwarding source.
REQ-018 valid_out  output  1  EX/MEM register holds a real instruction.
REQ-019 ctrl_out  output  5  registered ctrl_in.
REQ-020 alu_result_out  output  XLEN  registered result.
REQ-021 mux2_result_out  output  XLEN  registered forwarded operand B before aluSrc mux (store data).
REQ-022 reg_rd_out  output  RW  registered rd.
REQ-023 flag_beq_out  output  1  registered equality flag.

Function
REQ-024 Forwarding per operand: EX/MEM if write && rd!=0 && rd==rs; else MEM/WB under same test; else register input; EX/MEM wins when both match.
REQ-025 aluOp 00: A+B. 01: A-B, flag_beq = (A==B). 11: pass B.
REQ-026 aluOp 10, funct3: 000 add, or sub if funct7[5]&&!aluSrc; 111 and; 110 or; 100 xor; 001 sll; 101 srl/sra by funct7[5]; 010 signed slt (0/1); shift amount = B[log2(XLEN)-1:0]; all arithmetic modulo 2^XLEN.
REQ-027 aluOp 10, funct3 000, funct7 0000001, aluSrc 0: MUL, low XLEN bits of A*B, iterative shift-add, one bit per cycle.
REQ-028 Non-MUL with valid_in: outputs load at next edge (latency 1), stall_out low.
REQ-029 FSM IDLE/BUSY. IDLE + valid MUL: stall_out high combinationally, forwarded operands/ctrl/rd captured at edge, go BUSY with count = XLEN-1.
REQ-030 BUSY: stall_out high, count decrements per edge; stall_out is therefore high for exactly XLEN cycles starting with the accept cycle; at the edge leaving count 0, the product loads into the output registers with valid_out=1, and the FSM returns to IDLE.
REQ-031 Each edge without a completing instruction (valid_in low or MUL in progress) loads a bubble: valid_out=0, ctrl_out=0; other outputs don't-care.
REQ-032 Inputs are ignored while BUSY; operands captured at accept govern the result.
REQ-033 flush_in has priority over everything: bubble loaded, BUSY aborts to IDLE, stall_out low in the flush cycle.
REQ-034 flag_beq_out = 0 unless aluOp 01.

Reset
REQ-035 reset low: immediately all outputs 0, FSM IDLE, count 0, stall_out 0; reset mid-MUL discards it with no result.

Verification
REQ-036 ADD A=5,B=3,aluSrc=0 -> next edge alu_result_out=8, valid_out=1, stall_out never high.
REQ-037 SUB funct7=0100000 A=5,B=3 -> 2; OR 0x81000081|0x00818100 -> 0x81818181; aluOp 01 with A=B=0x10000005 -> flag_beq_out=1.
REQ-038 rs1=1,rs2=2; EX/MEM rd=1 data 9; MEM/WB rd=2 data 1; ADD -> 0xA. Both stages rd=1 -> EX/MEM value used. rs=0 -> never forwarded.
REQ-039 MUL 7x6 -> stall_out high 32 cycles, result 0x2A, valid_out=1 one edge later; 0xFFFFFFFF x 2 -> 0xFFFFFFFE.
REQ-040 flush_in at BUSY cycle 10 -> stall_out low, valid_out=0, next ADD completes in 1 cycle; reset low mid-MUL -> all outputs 0, no late result.
